// File: rtl/c499_ecc_pkg.sv
// Shared types and the reference check-bit equations for the c499 32-bit SEC code.
package c499_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam logic [5:0] INJ_NONE = 6'd40;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CHK_W-1:0]  chk_t;

  // Stage-1 payload: data plus the partial parities the check bits are built from.
  typedef struct packed {
    data_t      data;
    logic [7:0] nib_par;
    logic [7:0] stride_par;
    logic       inj_en;
    logic [5:0] inj_pos;
  } s1_t;

  typedef struct packed {
    data_t data;
    chk_t  check;
  } s2_t;

  function automatic chk_t ecc_check(input data_t d);
    chk_t c;
    c[0] = ^d[23:16] ^ d[0] ^ d[4] ^ d[8] ^ d[12];
    c[1] = ^d[31:24] ^ d[1] ^ d[5] ^ d[9] ^ d[13];
    c[2] = ^d[19:16] ^ ^d[27:24] ^ d[2] ^ d[6] ^ d[10] ^ d[14];
    c[3] = ^d[23:20] ^ ^d[31:28] ^ d[3] ^ d[7] ^ d[11] ^ d[15];
    c[4] = ^d[7:0] ^ d[16] ^ d[20] ^ d[24] ^ d[28];
    c[5] = ^d[15:8] ^ d[17] ^ d[21] ^ d[25] ^ d[29];
    c[6] = ^d[3:0] ^ ^d[11:8] ^ d[18] ^ d[22] ^ d[26] ^ d[30];
    c[7] = ^d[7:4] ^ ^d[15:12] ^ d[19] ^ d[23] ^ d[27] ^ d[31];
    return c;
  endfunction

endpackage

// File: rtl/c499_ecc_encoder_stream_if.sv
// Input and output streams of the c499 check-bit generator.
// Handshake: a word moves when valid & ready are both 1 on a rising edge; a
// producer holding valid with ready low keeps its payload stable, and valid
// may be withdrawn before a transfer takes place.
interface c499_ecc_encoder_stream_if;
  import c499_ecc_pkg::*;

  logic       in_valid;
  logic       in_ready;
  data_t      in_data;
  logic       inj_en;
  logic [5:0] inj_pos;
  logic       out_valid;
  logic       out_ready;
  data_t      out_data;
  chk_t       out_check;

  modport master (
    output in_valid, in_data, inj_en, inj_pos, out_ready,
    input  in_ready, out_valid, out_data, out_check
  );

  modport slave (
    input  in_valid, in_data, inj_en, inj_pos, out_ready,
    output in_ready, out_valid, out_data, out_check
  );
endinterface

// File: rtl/c499_pipe_stage.sv
// One valid/ready register slice; accepts whenever empty or draining this cycle.
module c499_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/c499_ecc_encoder_stream.sv
// Two-stage streaming SEC check-bit generator with optional single-bit fault injection.
module c499_ecc_encoder_stream
  import c499_ecc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter bit INJ_ENABLE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  c499_ecc_encoder_stream_if.slave  bus,
  output logic [CNT_W-1:0]          word_count
);

  s1_t        s1_d, s1_q;
  s2_t        s2_d, s2_q;
  logic       s1_valid;
  logic       s2_ready;
  chk_t       chk;
  data_t      flip_d;
  chk_t       flip_c;

  always_comb begin
    s1_d      = '0;
    s1_d.data = bus.in_data;
    for (int k = 0; k < 8; k++) s1_d.nib_par[k] = ^bus.in_data[4*k +: 4];
    for (int j = 0; j < 4; j++) begin
      s1_d.stride_par[j]   = bus.in_data[j] ^ bus.in_data[j+4] ^ bus.in_data[j+8] ^ bus.in_data[j+12];
      s1_d.stride_par[j+4] = bus.in_data[j+16] ^ bus.in_data[j+20] ^ bus.in_data[j+24] ^ bus.in_data[j+28];
    end
    s1_d.inj_en  = INJ_ENABLE ? bus.inj_en  : 1'b0;
    s1_d.inj_pos = INJ_ENABLE ? bus.inj_pos : INJ_NONE;
  end

  c499_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_q)
  );

  // Each check bit is two nibble parities plus one stride parity.
  always_comb begin
    chk[0] = s1_q.nib_par[4] ^ s1_q.nib_par[5] ^ s1_q.stride_par[0];
    chk[1] = s1_q.nib_par[6] ^ s1_q.nib_par[7] ^ s1_q.stride_par[1];
    chk[2] = s1_q.nib_par[4] ^ s1_q.nib_par[6] ^ s1_q.stride_par[2];
    chk[3] = s1_q.nib_par[5] ^ s1_q.nib_par[7] ^ s1_q.stride_par[3];
    chk[4] = s1_q.nib_par[0] ^ s1_q.nib_par[1] ^ s1_q.stride_par[4];
    chk[5] = s1_q.nib_par[2] ^ s1_q.nib_par[3] ^ s1_q.stride_par[5];
    chk[6] = s1_q.nib_par[0] ^ s1_q.nib_par[2] ^ s1_q.stride_par[6];
    chk[7] = s1_q.nib_par[1] ^ s1_q.nib_par[3] ^ s1_q.stride_par[7];
  end

  // Positions 0-31 hit data, 32-39 hit check bits, 40-63 hit nothing.
  always_comb begin
    flip_d = '0;
    flip_c = '0;
    if (s1_q.inj_en && !s1_q.inj_pos[5])
      flip_d = data_t'(1) << s1_q.inj_pos[4:0];
    if (s1_q.inj_en && s1_q.inj_pos[5:3] == 3'b100)
      flip_c = chk_t'(1) << s1_q.inj_pos[2:0];
    s2_d.data  = s1_q.data ^ flip_d;
    s2_d.check = chk ^ flip_c;
  end

  c499_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_d),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_q)
  );

  assign bus.out_data  = s2_q.data;
  assign bus.out_check = s2_q.check;

  always_ff @(posedge clk) begin
    if (rst)
      word_count <= '0;
    else if (bus.out_valid && bus.out_ready && word_count != {CNT_W{1'b1}})
      word_count <= word_count + CNT_W'(1);
  end

endmodule
